// File: rtl/circuito_exp5_pkg.sv
// circuito_exp5_pkg: FSM state codes, sequence ROM and default timeout for the Genius game core.
package circuito_exp5_pkg;
    localparam int TIMEOUT_CYCLES_DEF = 3000;
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;
    // Entry 15 first, entry 0 last: ROM[i] is sequence entry i.
    localparam logic [15:0][3:0] ROM = {
        4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
        4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1
    };
endpackage

// File: rtl/hexa7seg.sv
// hexa7seg: 4-bit hex digit to active-low seven-segment pattern (bit0=a .. bit6=g).
module hexa7seg (
    input  logic [3:0] hexa_i,
    output logic [6:0] sseg_o
);
    localparam logic [15:0][6:0] SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    assign sseg_o = SEG[hexa_i];
endmodule

// File: rtl/circuito_exp5.sv
// circuito_exp5: Genius-style sequence-memory game core (datapath, FSM, timer, 7-seg debug).
// Define TIMEOUT_EN to enable the per-play idle timeout and the fim_timeout state.
module circuito_exp5
    import circuito_exp5_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igualE,
    output logic       db_igualL,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_tem_jogada,
    output logic       db_timeout,
    output logic       db_contaL,
    output logic [6:0] db_limite
);
`ifdef TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    estado_t       state_q, state_d;
    logic [3:0]    addr_q, lim_q, jog_q;
    logic [TW-1:0] timer_q;
    logic          tem_q, acertou_q, errou_q, pronto_q, timeout_q, contal_q;
    logic          jogada, tmo;

    assign db_tem_jogada = |botoes;
    assign jogada        = db_tem_jogada & ~tem_q;
    assign db_igualE     = jog_q == ROM[addr_q];
    assign db_igualL     = addr_q == lim_q;
    // With TIMEOUT_EN undefined the timer stays at zero and this is constant low.
    assign tmo           = TMO_EN && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = INICIAL;
        case (state_q)
            INICIAL:        state_d = jogar ? PREPARACAO : INICIAL;
            PREPARACAO:     state_d = INICIO_RODADA;
            INICIO_RODADA:  state_d = ESPERA;
            ESPERA:         state_d = jogada ? REGISTRA : tmo ? FIM_TIMEOUT : ESPERA;
            REGISTRA:       state_d = COMPARACAO;
            COMPARACAO:     state_d = !db_igualE ? FIM_ERRO : db_igualL ? PROXIMA_RODADA : PROXIMO;
            PROXIMO:        state_d = ESPERA;
            PROXIMA_RODADA: state_d = lim_q == 4'hF ? FIM_ACERTO : INICIO_RODADA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                            state_d = jogar ? PREPARACAO : state_q;
            default:        state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q   <= INICIAL;
            addr_q    <= '0;
            lim_q     <= '0;
            jog_q     <= '0;
            timer_q   <= '0;
            tem_q     <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            pronto_q  <= 1'b0;
            timeout_q <= 1'b0;
            contal_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tem_q     <= db_tem_jogada;
            timer_q   <= (TMO_EN && state_q == ESPERA && state_d == ESPERA) ? timer_q + 1'b1 : '0;
            addr_q    <= (state_q == PREPARACAO || state_q == INICIO_RODADA) ? '0 :
                         state_q == PROXIMO ? addr_q + 1'b1 : addr_q;
            lim_q     <= state_q == PREPARACAO ? '0 :
                         (state_q == PROXIMA_RODADA && lim_q != 4'hF) ? lim_q + 1'b1 : lim_q;
            jog_q     <= state_q == PREPARACAO ? '0 : state_q == REGISTRA ? botoes : jog_q;
            // Moore outputs registered from the next state so they align with state_q.
            acertou_q <= state_d == FIM_ACERTO;
            errou_q   <= state_d == FIM_ERRO || state_d == FIM_TIMEOUT;
            pronto_q  <= state_d == FIM_ACERTO || state_d == FIM_ERRO || state_d == FIM_TIMEOUT;
            timeout_q <= state_d == FIM_TIMEOUT;
            contal_q  <= state_d == PROXIMA_RODADA && lim_q != 4'hF;
        end

    assign acertou    = acertou_q;
    assign errou      = errou_q;
    assign pronto     = pronto_q;
    assign db_timeout = timeout_q;
    assign db_contaL  = contal_q;
    assign leds       = jog_q;
    assign db_clock   = clock;

    hexa7seg u_hex_cont (.hexa_i(addr_q),       .sseg_o(db_contagem));
    hexa7seg u_hex_mem  (.hexa_i(ROM[addr_q]),  .sseg_o(db_memoria));
    hexa7seg u_hex_est  (.hexa_i(state_q),      .sseg_o(db_estado));
    hexa7seg u_hex_jog  (.hexa_i(jog_q),        .sseg_o(db_jogadafeita));
    hexa7seg u_hex_lim  (.hexa_i(lim_q),        .sseg_o(db_limite));
endmodule

// File: tb/tb_circuito_exp5.sv
// tb_circuito_exp5: directed, table-driven bench for the circuito_exp5 game core.
module tb_circuito_exp5;
    localparam int T = 40;
    localparam logic [15:0][6:0] SEG_ON = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [3:0] SEQ [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    logic       clock = 1'b0, reset, jogar;
    logic [3:0] botoes;
    logic       acertou, errou, pronto, db_igualE, db_igualL, db_clock;
    logic       db_tem_jogada, db_timeout, db_contaL;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;
    int         checks = 0, errors = 0;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] st;
        logic [3:0] lim;
        logic       igl;
    } vec_t;
    vec_t v [9];

    circuito_exp5 #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igualE(db_igualE), .db_igualL(db_igualL), .db_contagem(db_contagem),
        .db_memoria(db_memoria), .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
        .db_clock(db_clock), .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout),
        .db_contaL(db_contaL), .db_limite(db_limite)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [6:0] seg(input logic [3:0] h);
        return ~SEG_ON[h];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_espera();
        int n = 0;
        while (db_estado !== seg(4'h3) && n < 10) begin
            step(1);
            n++;
        end
        if (db_estado !== seg(4'h3)) begin
            checks++;
            errors++;
            $display("FAIL wait_espera: estado %h expected %h", db_estado, seg(4'h3));
        end
    endtask

    task automatic play(input logic [3:0] b);
        botoes = b;
        step(3);
    endtask

    task automatic start();
        jogar = 1'b1;
        step(1);
        jogar = 1'b0;
        step(2);
    endtask

    initial begin
        v[0] = '{4'h1, 4'h7, 4'h0, 1'b1};
        v[1] = '{4'h1, 4'h6, 4'h1, 1'b0};
        v[2] = '{4'h2, 4'h7, 4'h1, 1'b1};
        v[3] = '{4'h1, 4'h6, 4'h2, 1'b0};
        v[4] = '{4'h2, 4'h6, 4'h2, 1'b0};
        v[5] = '{4'h4, 4'h7, 4'h2, 1'b1};
        v[6] = '{4'h1, 4'h6, 4'h3, 1'b0};
        v[7] = '{4'h2, 4'h6, 4'h3, 1'b0};
        v[8] = '{4'h2, 4'hE, 4'h3, 1'b0};
        reset = 1'b0;
        jogar = 1'b0;
        botoes = 4'h0;
        step(1);
        chk("rst_estado", db_estado, seg(4'h0));
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_acertou", acertou, 1'b0);
        chk("rst_errou", errou, 1'b0);
        chk("rst_leds", leds, 4'h0);
        chk("rst_limite", db_limite, seg(4'h0));
        chk("rst_timeout", db_timeout, 1'b0);
        chk("rst_contaL", db_contaL, 1'b0);
        reset = 1'b1;
        botoes = 4'h4;
        step(5);
        chk("idle_estado", db_estado, seg(4'h0));
        chk("tem_jogada", db_tem_jogada, 1'b1);
        chk("db_clock", db_clock, clock);
        botoes = 4'h0;
        step(1);
        jogar = 1'b1;
        step(1);
        chk("prep_estado", db_estado, seg(4'h1));
        jogar = 1'b0;
        step(2);
        chk("start_espera", db_estado, seg(4'h3));
        chk("start_limite", db_limite, seg(4'h0));
        for (int i = 0; i < 9; i++) begin
            play(v[i].btn);
            chk($sformatf("v%0d_estado", i), db_estado, seg(v[i].st));
            chk($sformatf("v%0d_limite", i), db_limite, seg(v[i].lim));
            chk($sformatf("v%0d_igualL", i), db_igualL, v[i].igl);
            chk($sformatf("v%0d_igualE", i), db_igualE, v[i].st != 4'hE);
            chk($sformatf("v%0d_contaL", i), db_contaL, v[i].st == 4'h7);
            chk($sformatf("v%0d_leds", i), leds, v[i].btn);
            chk($sformatf("v%0d_jogada", i), db_jogadafeita, seg(v[i].btn));
            botoes = 4'h0;
            if (v[i].st != 4'hE) wait_espera();
        end
        chk("loss_errou", errou, 1'b1);
        chk("loss_pronto", pronto, 1'b1);
        chk("loss_acertou", acertou, 1'b0);
        chk("loss_contagem", db_contagem, seg(4'h2));
        chk("loss_memoria", db_memoria, seg(4'h4));
        botoes = 4'h8;
        step(5);
        botoes = 4'h0;
        chk("loss_hold_estado", db_estado, seg(4'hE));
        chk("loss_hold_errou", errou, 1'b1);
        chk("loss_hold_leds", leds, 4'h2);
        start();
        chk("g2_espera", db_estado, seg(4'h3));
        chk("g2_limite", db_limite, seg(4'h0));
        chk("g2_leds", leds, 4'h0);
        chk("g2_errou", errou, 1'b0);
        play(4'h1);
        chk("g2_r1", db_estado, seg(4'h7));
        botoes = 4'h0;
        wait_espera();
        play(4'h1);
        chk("g2_r2a", db_estado, seg(4'h6));
        step(4);
        chk("g2_held_once", db_estado, seg(4'h3));
        botoes = 4'h0;
        step(1);
        play(4'h4);
        chk("g2_r2b", db_estado, seg(4'hE));
        chk("g2_errou", errou, 1'b1);
        botoes = 4'h0;
        start();
        chk("tmo_espera", db_estado, seg(4'h3));
        step(T - 1);
        chk("tmo_before", db_estado, seg(4'h3));
        step(1);
`ifdef TIMEOUT_EN
        chk("tmo_estado", db_estado, seg(4'hD));
        chk("tmo_flag", db_timeout, 1'b1);
        chk("tmo_errou", errou, 1'b1);
        chk("tmo_pronto", pronto, 1'b1);
        start();
`else
        chk("notmo_estado", db_estado, seg(4'h3));
        chk("notmo_flag", db_timeout, 1'b0);
        chk("notmo_errou", errou, 1'b0);
`endif
        chk("pre_mid_espera", db_estado, seg(4'h3));
        play(4'h1);
        chk("mid_r1", db_estado, seg(4'h7));
        botoes = 4'h0;
        wait_espera();
        chk("mid_limite", db_limite, seg(4'h1));
        #3 reset = 1'b0;
        #1;
        chk("async_estado", db_estado, seg(4'h0));
        chk("async_limite", db_limite, seg(4'h0));
        chk("async_leds", leds, 4'h0);
        step(1);
        reset = 1'b1;
        step(1);
        start();
        chk("win_start", db_estado, seg(4'h3));
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) begin
                play(SEQ[i]);
                chk($sformatf("win_r%0d_p%0d", r, i), db_estado, seg(i == r ? 4'h7 : 4'h6));
                botoes = 4'h0;
                if (r != 15 || i != 15) wait_espera();
            end
        end
        chk("win_last_contaL", db_contaL, 1'b0);
        chk("win_last_limite", db_limite, seg(4'hF));
        step(1);
        chk("win_estado", db_estado, seg(4'hA));
        chk("win_acertou", acertou, 1'b1);
        chk("win_pronto", pronto, 1'b1);
        chk("win_errou", errou, 1'b0);
        step(3);
        chk("win_hold_estado", db_estado, seg(4'hA));
        chk("win_hold_limite", db_limite, seg(4'hF));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
